// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, state encoding and helpers for the mux8_rr_sched slice.
// The optional lock feature of mux8_rr_sched is enabled by MUX8_RR_LOCK_EN.
package mux8_rr_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    // Beat counter width: holds 0..MAX_BURST-1 for MAX_BURST up to 15.
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_sched_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// searching ptr+1, ptr+2, ... and wrapping around to ptr itself.
module rr_pick
    import mux8_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any_req,
    output logic [SEL_W-1:0] win_idx
);

    // Request vector rotated so bit 0 is the highest-priority candidate (ptr+1).
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] offset;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [SEL_W-1:0] src_idx;
            assign src_idx = ptr + SEL_W'(gi + 1);
            assign rot[gi] = req[src_idx];
        end
    endgenerate

    // Priority-encode the rotated vector; the lowest set bit wins.
    always_comb begin
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign any_req = |req;
    // Modulo-8 wrap comes for free from the 3-bit addition.
    assign win_idx = ptr + SEL_W'(1) + offset;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing an 8:1 data select among eight requesters,
// with bounded bursts and back-to-back regrant on release.
// Optional feature: define MUX8_RR_LOCK_EN to add the lock input, which
// suppresses the burst limit while held in GRANT.
module mux8_rr_sched
    import mux8_rr_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   din,
`ifdef MUX8_RR_LOCK_EN
    input  logic                  lock,
`endif
    output logic [N_REQ-1:0]      gnt,
    output logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [N_REQ-1:0]  gnt_reg, gnt_next;
    logic [SEL_W-1:0]  ptr_reg, ptr_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;

    logic              granted;
    logic              xfer;
    logic              at_limit;
    logic              burst_done;
    logic              release_now;
    logic [SEL_W-1:0]  pick_ptr;
    logic              any_req;
    logic [SEL_W-1:0]  win_idx;

    assign granted   = (state_reg == GRANT);
    assign out_valid = granted && req[sel_reg];
    assign out_data  = din[sel_reg*DW +: DW];
    assign xfer      = out_valid && out_ready;
    assign at_limit  = (beat_cnt_reg == BURST_LAST);

`ifdef MUX8_RR_LOCK_EN
    assign burst_done = xfer && at_limit && !lock;
`else
    assign burst_done = xfer && at_limit;
`endif

    assign release_now = granted && (!req[sel_reg] || burst_done);

    // While granted, the search starts after the current owner (which becomes
    // ptr on release); in IDLE, ptr already holds the last released owner.
    assign pick_ptr = granted ? sel_reg : ptr_reg;

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .any_req (any_req),
        .win_idx (win_idx)
    );

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            gnt_reg      <= '0;
            ptr_reg      <= SEL_W'(N_REQ - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            gnt_reg      <= gnt_next;
            ptr_reg      <= ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state logic: grant from IDLE, count beats, release and regrant.
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        gnt_next      = gnt_reg;
        ptr_next      = ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = GRANT;
                    sel_next      = win_idx;
                    gnt_next      = onehot(win_idx);
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_next = sel_reg;
                    if (any_req) begin
                        sel_next      = win_idx;
                        gnt_next      = onehot(win_idx);
                        beat_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else if (xfer && !at_limit) begin
                    // Without release the counter stops at the last beat
                    // (only reachable while locked).
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign gnt  = gnt_reg;
    assign sel  = sel_reg;
    assign busy = granted;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched (default build, lock feature off).
module tb_mux8_rr_sched;

    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        req = '0;
    logic [8*DW-1:0]   din = '0;
    logic [7:0]        gnt;
    logic [2:0]        sel;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 when idle), last released owner,
    // select value and beats accepted in the current grant.
    int m_owner, m_ptr, m_sel, m_beats;

    // Expected outputs for the cycle just driven.
    logic [7:0]    exp_gnt;
    logic [2:0]    exp_sel;
    logic          exp_busy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;

    mux8_rr_sched #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int find_winner(input logic [7:0] r, input int start);
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (start + k) % 8;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 7;
        m_sel   = 0;
        m_beats = 0;
    endtask

    // Advance the model by one clock edge given the inputs of this cycle.
    task automatic model_step(input logic [7:0] r, input logic rdy);
        int  w;
        bit  x;
        if (m_owner < 0) begin
            w = find_winner(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_beats = 0;
            end
        end else begin
            x = r[m_owner] && rdy;
            if (!r[m_owner] || (x && (m_beats + 1 == MAX_BURST))) begin
                m_ptr = m_owner;
                w = find_winner(r, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (x) begin
                m_beats++;
            end
        end
    endtask

    // Drive one cycle of inputs on the falling edge, compute the expected
    // outputs for it, then advance the model across the next rising edge.
    task automatic drive(input logic [7:0] r, input logic rdy, input bit new_din);
        @(negedge clk);
        req = r;
        out_ready = rdy;
        if (new_din) begin
            for (int i = 0; i < 8; i++) din[i*DW +: DW] = DW'($urandom);
        end
        #1;
        exp_busy  = (m_owner >= 0);
        exp_gnt   = exp_busy ? (8'd1 << m_owner) : 8'd0;
        exp_sel   = 3'(m_sel);
        exp_valid = exp_busy && r[m_owner];
        exp_data  = exp_busy ? din[m_owner*DW +: DW] : '0;
        model_step(r, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 8'hFF;
        #1;
        checks++;
        if ({gnt, sel, out_valid, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%h sel=%0d valid=%b busy=%b, required all zero",
                     gnt, sel, out_valid, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = '0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int beats = 0;
        do_reset();
        drive(8'h01, 1'b1, 1);
        checks++;
        if (busy !== 1'b0 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL single_idle: gnt=%h busy=%b, required 00/0", gnt, busy);
        end
        for (int k = 1; k <= 9; k++) begin
            drive(8'h01, 1'b1, 1);
            if (out_valid && out_ready) beats++;
            checks++;
            if (gnt !== 8'h01 || sel !== 3'd0 || out_valid !== 1'b1 || out_data !== din[DW-1:0]) begin
                errors++;
                $display("FAIL single_grant cyc%0d: gnt=%h sel=%0d valid=%b data=%h, required 01/0/1/%h",
                         k, gnt, sel, out_valid, out_data, din[DW-1:0]);
            end
            $display("single cyc%0d gnt=%h sel=%0d valid=%b", k, gnt, sel, out_valid);
        end
        checks++;
        if (beats !== 9) begin
            errors++;
            $display("FAIL single_beats: got %0d, required 9", beats);
        end
    endtask

    task automatic test_all_requesters();
        logic [2:0] e_sel;
        do_reset();
        drive(8'hFF, 1'b1, 1);
        for (int k = 1; k <= 33; k++) begin
            drive(8'hFF, 1'b1, 1);
            e_sel = 3'(((k - 1) / MAX_BURST) % 8);
            checks++;
            if (sel !== e_sel || gnt !== (8'd1 << e_sel) || out_valid !== 1'b1 ||
                out_data !== din[e_sel*DW +: DW]) begin
                errors++;
                $display("FAIL all_rr cyc%0d: sel=%0d gnt=%h valid=%b, required sel=%0d valid=1",
                         k, sel, gnt, out_valid, e_sel);
            end
            $display("all cyc%0d sel=%0d gnt=%h", k, sel, gnt);
        end
    endtask

    task automatic test_ptr_order();
        do_reset();
        drive(8'h20, 1'b1, 1);
        drive(8'h20, 1'b1, 1);
        drive(8'h00, 1'b1, 1);
        drive(8'h24, 1'b1, 1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ptr_idle: busy=%b, required 0", busy);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(8'h24, 1'b1, 1);
            checks++;
            if (sel !== 3'd2 || gnt !== 8'h04) begin
                errors++;
                $display("FAIL ptr_first beat%0d: sel=%0d gnt=%h, required 2/04", k, sel, gnt);
            end
            $display("ptr beat%0d sel=%0d", k, sel);
        end
        drive(8'h24, 1'b1, 1);
        checks++;
        if (sel !== 3'd5 || gnt !== 8'h20 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ptr_second: sel=%0d gnt=%h valid=%b, required 5/20/1", sel, gnt, out_valid);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] held;
        do_reset();
        drive(8'h08, 1'b0, 1);
        held = din[3*DW +: DW];
        for (int k = 1; k <= 5; k++) begin
            drive(8'h08, 1'b0, 0);
            checks++;
            if (out_valid !== 1'b1 || sel !== 3'd3 || out_data !== held || gnt !== 8'h08) begin
                errors++;
                $display("FAIL stall cyc%0d: valid=%b sel=%0d data=%h gnt=%h, required 1/3/%h/08",
                         k, out_valid, sel, out_data, gnt, held);
            end
            $display("stall cyc%0d valid=%b data=%h", k, out_valid, out_data);
        end
        for (int k = 1; k <= 6; k++) begin
            drive(8'h08, 1'b1, 1);
            checks++;
            if (gnt !== exp_gnt || sel !== exp_sel || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL stall_resume cyc%0d: gnt=%h sel=%0d valid=%b, required %h/%0d/%b",
                         k, gnt, sel, out_valid, exp_gnt, exp_sel, exp_valid);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        drive(8'h40, 1'b1, 1);
        drive(8'h42, 1'b1, 1);
        drive(8'h42, 1'b1, 1);
        checks++;
        if (sel !== 3'd6) begin
            errors++;
            $display("FAIL drop_owner: sel=%0d, required 6", sel);
        end
        drive(8'h02, 1'b1, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_valid: valid=%b, required 0", out_valid);
        end
        for (int k = 1; k <= 5; k++) begin
            drive(8'h02, 1'b1, 1);
            checks++;
            if (sel !== exp_sel || gnt !== exp_gnt || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL drop_regrant cyc%0d: sel=%0d gnt=%h valid=%b, required %0d/%h/%b",
                         k, sel, gnt, out_valid, exp_sel, exp_gnt, exp_valid);
            end
            $display("drop cyc%0d sel=%0d gnt=%h", k, sel, gnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(8'h01, 1'b1, 1);
        drive(8'h01, 1'b1, 1);
        drive(8'h01, 1'b1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: gnt=%h valid=%b busy=%b sel=%0d, required 00/0/0/0",
                     gnt, out_valid, busy, sel);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h30, 1'b1, 1);
        drive(8'h30, 1'b1, 1);
        checks++;
        if (sel !== 3'd4 || gnt !== 8'h10) begin
            errors++;
            $display("FAIL reset_mid_regrant: sel=%0d gnt=%h, required 4/10", sel, gnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int bad = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            drive(r, ($urandom_range(0, 3) != 0), 1);
            checks++;
            if (gnt !== exp_gnt || sel !== exp_sel || busy !== exp_busy || out_valid !== exp_valid ||
                (exp_valid && out_data !== exp_data)) begin
                errors++;
                bad++;
                $display("FAIL random cyc%0d: gnt=%h sel=%0d busy=%b valid=%b data=%h, required %h/%0d/%b/%b/%h",
                         k, gnt, sel, busy, out_valid, out_data, exp_gnt, exp_sel, exp_busy, exp_valid, exp_data);
            end
        end
        $display("test_random: 400 cycles, %0d bad", bad);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_requesters();
        test_ptr_order();
        test_stall();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
